uart_fifo_thr: RTL and testbench
================================

Name: uart_fifo_thr

Overview:
Next-generation UART FIFO, used for both TX and RX buffering in the UART core.
- Generalises the basic FIFO with a build-time first-word-fall-through (FWFT) mode and programmable almost-empty/almost-full thresholds.
- Adds synchronous flush, a sticky underrun flag, a resettable high-water mark, and read+write while full.
- Sits between the register interface and the TX/RX shift engines; the threshold flags drive UART interrupts.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, entry count; any value >= 2 (power of two not required).
- FWFT, 0, 0 = registered read with 1-cycle latency; 1 = head word presented combinationally and ren_i acts as pop/ack.
- LVL_W, $clog2(DEPTH+1), localparam; width of the level and threshold buses (must represent DEPTH).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- wdata_i  in  WIDTH  write data.
- wen_i  in  1  write request.
- ren_i  in  1  read request (FWFT: pop the head word).
- rdata_o  out  WIDTH  read data.
- valid_o  out  1  rdata_o holds a valid word.
- flush_i  in  1  synchronous flush (empties the FIFO).
- ae_thr_i  in  LVL_W  almost-empty threshold.
- af_thr_i  in  LVL_W  almost-full threshold.
- clr_ovrn_i  in  1  clear the overrun flag.
- clr_udrn_i  in  1  clear the underrun flag.
- clr_hwm_i  in  1  reload the high-water mark.
- ovrn_o  out  1  sticky: a write was dropped.
- udrn_o  out  1  sticky: a read was made while empty.
- lvl_o  out  LVL_W  current occupancy, 0..DEPTH.
- hwm_o  out  LVL_W  peak occupancy since reset or clear.
- empty_o  out  1  lvl_o == 0.
- full_o  out  1  lvl_o == DEPTH.
- almost_empty_o  out  1  lvl_o <= ae_thr_i.
- almost_full_o  out  1  lvl_o >= af_thr_i.

Behaviour:
- Reset (async assert, any cycle including mid-transfer) clears:
  - pointers, lvl_o, hwm_o, ovrn_o, udrn_o, valid_o and rdata_o, all to 0.
  - Storage array is not reset.
- Acceptance rules:
  - wr_ok = wen_i & ~flush_i & (~full_o | rd_ok).
  - rd_ok = ren_i & ~flush_i & ~empty_o.
- Full and empty corner cases:
  - Read+write while full: both accepted, level unchanged.
  - Read+write while empty: write accepted, read rejected and udrn_o set.
  - No FWFT bypass: a word written into an empty FIFO is readable the next cycle.
- Pointers advance by 1 per accepted access. At DEPTH-1 the pointer wraps to 0 explicitly (no reliance on modulo 2^n).
- Level update: lvl_o +1 on write-only, -1 on read-only, otherwise unchanged.
- Standard mode (FWFT=0):
  - rdata_o is registered from the head entry on rd_ok; valid_o is high for exactly the following cycle.
  - rdata_o holds its last value otherwise.
- FWFT mode:
  - rdata_o = head entry when ~empty_o, else 0; valid_o = ~empty_o.
  - ren_i with valid_o high consumes the word; the next head word appears the following cycle.
- Flush (flush_i=1):
  - Next cycle: pointers=0, lvl_o=0, valid_o=0.
  - The same-cycle write and read are discarded; they set neither ovrn_o nor udrn_o.
  - hwm_o and the sticky flags are untouched.
- ovrn_o:
  - Set on wen_i & full_o & ~rd_ok & ~flush_i.
  - Cleared by clr_ovrn_i; set wins over clear in the same cycle.
- udrn_o: set on ren_i & empty_o & ~flush_i; cleared by clr_udrn_i; set wins over clear.
- hwm_o: each cycle hwm <= clr_hwm_i ? lvl_next : max(hwm, lvl_next), where lvl_next is the post-update level.
- Threshold flags:
  - Combinational from registered lvl_o and the threshold inputs; thresholds may change at any time.
  - af_thr_i=0 forces almost_full_o=1; ae_thr_i >= DEPTH forces almost_empty_o=1.

Decomposition:
- uart_pkg gains:
  - function fifo_lvl_w(depth) returning $clog2(depth+1);
  - the FWFT mode enum typedef fifo_mode_e {FIFO_STD, FIFO_FWFT}.
- Sub-module uart_fifo_ram holds the storage: one write port and an asynchronous read at an address.
- Control, flags and hwm stay in uart_fifo_thr.

Test Plan:
- DEPTH=4, FWFT=0: write A,B,C,D -> full_o=1, lvl_o=4. Write E -> ovrn_o=1, E dropped. Read x4 -> A..D, each with valid_o one cycle after ren_i.
- Full, ren_i and wen_i both high with wdata=E -> lvl_o stays 4, ovrn_o=0. Subsequent reads return B,C,D,E.
- FWFT=1: write 0x5A into an empty FIFO -> next cycle valid_o=1, rdata_o=0x5A. Pulse ren_i -> empty_o=1, rdata_o=0. ren_i while empty -> udrn_o=1. clr_udrn_i -> udrn_o=0.
- af_thr_i=3, ae_thr_i=1: fill 0->4 -> almost_full_o rises at lvl_o=3, almost_empty_o falls at lvl_o=2. hwm_o=4. clr_hwm_i at lvl_o=2 -> hwm_o=2.
- lvl_o=3 with flush_i and wen_i in the same cycle -> lvl_o=0, ovrn_o unchanged, then write F and read F. Pointers at wrap (DEPTH=5) -> order preserved across 12 writes/reads.
- Assert reset_i asynchronously mid-burst (between clock edges) -> all outputs 0 immediately, and a normal write/read works after deassert.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART FIFO blocks.
package uart_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int fifo_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_thr.sv
// UART FIFO with optional first-word-fall-through, threshold flags,
// sticky overrun/underrun, flush and a high-water mark.
module uart_fifo_thr
    import uart_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    parameter  int FWFT  = 0,
    localparam int LVL_W = fifo_lvl_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             wen_i,
    input  logic             ren_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    input  logic             flush_i,
    input  logic [LVL_W-1:0] ae_thr_i,
    input  logic [LVL_W-1:0] af_thr_i,
    input  logic             clr_ovrn_i,
    input  logic             clr_udrn_i,
    input  logic             clr_hwm_i,
    output logic             ovrn_o,
    output logic             udrn_o,
    output logic [LVL_W-1:0] lvl_o,
    output logic [LVL_W-1:0] hwm_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_empty_o,
    output logic             almost_full_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam fifo_mode_e       MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d, hwm_q, hwm_d;
    logic             ovrn_q, ovrn_d, udrn_q, udrn_d;
    logic             rd_ok, wr_ok;
    logic [WIDTH-1:0] head;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == DEPTH_L);

    always_comb begin
        rd_ok  = ren_i & ~flush_i & ~empty_o;
        wr_ok  = wen_i & ~flush_i & (~full_o | rd_ok);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        lvl_d  = lvl_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            lvl_d  = '0;
        end else begin
            if (wr_ok) wptr_d = ptr_inc(wptr_q);
            if (rd_ok) rptr_d = ptr_inc(rptr_q);
            if (wr_ok & ~rd_ok) lvl_d = lvl_q + 1'b1;
            if (rd_ok & ~wr_ok) lvl_d = lvl_q - 1'b1;
        end
        // Set takes priority over clear on both sticky flags.
        ovrn_d = (wen_i & full_o & ~rd_ok & ~flush_i) | (ovrn_q & ~clr_ovrn_i);
        udrn_d = (ren_i & empty_o & ~flush_i) | (udrn_q & ~clr_udrn_i);
        hwm_d  = (clr_hwm_i || lvl_d > hwm_q) ? lvl_d : hwm_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
            hwm_q  <= '0;
            ovrn_q <= 1'b0;
            udrn_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
            hwm_q  <= hwm_d;
            ovrn_q <= ovrn_d;
            udrn_q <= udrn_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_ok),
        .waddr_i (wptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign rdata_o = empty_o ? '0 : head;
            assign valid_o = ~empty_o;
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            logic             rvld_q;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rvld_q <= rd_ok;
                    if (rd_ok) rdata_q <= head;
                end
            end

            assign rdata_o = rdata_q;
            assign valid_o = rvld_q;
        end
    endgenerate

    assign lvl_o          = lvl_q;
    assign hwm_o          = hwm_q;
    assign ovrn_o         = ovrn_q;
    assign udrn_o         = udrn_q;
    assign almost_empty_o = (lvl_q <= ae_thr_i);
    assign almost_full_o  = (lvl_q >= af_thr_i);

endmodule

// File: tb/tb_uart_fifo_thr.sv
// Directed bench for uart_fifo_thr: standard DEPTH=4, FWFT DEPTH=4 and
// standard DEPTH=5 instances share one set of inputs.
module tb_uart_fifo_thr;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [7:0] wdata_i;
    logic       wen_i, ren_i, flush_i;
    logic [2:0] ae_thr_i, af_thr_i;
    logic       clr_ovrn_i, clr_udrn_i, clr_hwm_i;

    logic [7:0] s4_rdata, f4_rdata, s5_rdata;
    logic       s4_valid, f4_valid, s5_valid;
    logic       s4_ovrn, f4_ovrn, s5_ovrn, s4_udrn, f4_udrn, s5_udrn;
    logic [2:0] s4_lvl, f4_lvl, s5_lvl, s4_hwm, f4_hwm, s5_hwm;
    logic       s4_empty, f4_empty, s5_empty, s4_full, f4_full, s5_full;
    logic       s4_ae, f4_ae, s5_ae, s4_af, f4_af, s5_af;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    uart_fifo_thr #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_s4 (
        .clk_i(clk), .reset_i(reset_i), .wdata_i(wdata_i), .wen_i(wen_i), .ren_i(ren_i),
        .rdata_o(s4_rdata), .valid_o(s4_valid), .flush_i(flush_i),
        .ae_thr_i(ae_thr_i), .af_thr_i(af_thr_i), .clr_ovrn_i(clr_ovrn_i),
        .clr_udrn_i(clr_udrn_i), .clr_hwm_i(clr_hwm_i), .ovrn_o(s4_ovrn), .udrn_o(s4_udrn),
        .lvl_o(s4_lvl), .hwm_o(s4_hwm), .empty_o(s4_empty), .full_o(s4_full),
        .almost_empty_o(s4_ae), .almost_full_o(s4_af));

    uart_fifo_thr #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_f4 (
        .clk_i(clk), .reset_i(reset_i), .wdata_i(wdata_i), .wen_i(wen_i), .ren_i(ren_i),
        .rdata_o(f4_rdata), .valid_o(f4_valid), .flush_i(flush_i),
        .ae_thr_i(ae_thr_i), .af_thr_i(af_thr_i), .clr_ovrn_i(clr_ovrn_i),
        .clr_udrn_i(clr_udrn_i), .clr_hwm_i(clr_hwm_i), .ovrn_o(f4_ovrn), .udrn_o(f4_udrn),
        .lvl_o(f4_lvl), .hwm_o(f4_hwm), .empty_o(f4_empty), .full_o(f4_full),
        .almost_empty_o(f4_ae), .almost_full_o(f4_af));

    uart_fifo_thr #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_s5 (
        .clk_i(clk), .reset_i(reset_i), .wdata_i(wdata_i), .wen_i(wen_i), .ren_i(ren_i),
        .rdata_o(s5_rdata), .valid_o(s5_valid), .flush_i(flush_i),
        .ae_thr_i(ae_thr_i), .af_thr_i(af_thr_i), .clr_ovrn_i(clr_ovrn_i),
        .clr_udrn_i(clr_udrn_i), .clr_hwm_i(clr_hwm_i), .ovrn_o(s5_ovrn), .udrn_o(s5_udrn),
        .lvl_o(s5_lvl), .hwm_o(s5_hwm), .empty_o(s5_empty), .full_o(s5_full),
        .almost_empty_o(s5_ae), .almost_full_o(s5_af));

    typedef struct {
        logic       wen, ren, flush;
        logic [7:0] wd;
        logic       co, cu, ch;
        logic [7:0] rd;
        logic       vl;
        logic [2:0] lvl, hwm;
        logic       full, empty, ae, af, ov, ud;
    } vec_t;

    function automatic vec_t mk(int wen, int ren, int flush, int wd, int co, int cu, int ch,
                                int rd, int vl, int lvl, int hwm, int full, int empty,
                                int ae, int af, int ov, int ud);
        vec_t m;
        m.wen = wen[0]; m.ren = ren[0]; m.flush = flush[0]; m.wd = wd[7:0];
        m.co = co[0]; m.cu = cu[0]; m.ch = ch[0];
        m.rd = rd[7:0]; m.vl = vl[0]; m.lvl = lvl[2:0]; m.hwm = hwm[2:0];
        m.full = full[0]; m.empty = empty[0]; m.ae = ae[0]; m.af = af[0];
        m.ov = ov[0]; m.ud = ud[0];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic w, input logic r, input logic f, input logic [7:0] d);
        wen_i = w; ren_i = r; flush_i = f; wdata_i = d;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        clr_ovrn_i = 1'b0; clr_udrn_i = 1'b0; clr_hwm_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    vec_t vt[21];

    initial begin
        reset_i = 1'b1;
        ae_thr_i = 3'd1;
        af_thr_i = 3'd3;
        idle_in();
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;

        chk("rst_lvl", 32'(s4_lvl), 0);
        chk("rst_hwm", 32'(s4_hwm), 0);
        chk("rst_valid", 32'(s4_valid), 0);
        chk("rst_rdata", 32'(s4_rdata), 0);
        chk("rst_empty", 32'(s4_empty), 1);
        chk("rst_flags", 32'({s4_ovrn, s4_udrn, s4_full}), 0);

        //          wen ren fl wd    co cu ch  rd    vl lvl hwm full emp ae af ov ud
        vt[0]  = mk(1, 0, 0, 'hA1, 0, 0, 0, 'h00, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        vt[1]  = mk(1, 0, 0, 'hB2, 0, 0, 0, 'h00, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(1, 0, 0, 'hC3, 0, 0, 0, 'h00, 0, 3, 3, 0, 0, 0, 1, 0, 0);
        vt[3]  = mk(1, 0, 0, 'hD4, 0, 0, 0, 'h00, 0, 4, 4, 1, 0, 0, 1, 0, 0);
        vt[4]  = mk(1, 0, 0, 'hE5, 0, 0, 0, 'h00, 0, 4, 4, 1, 0, 0, 1, 1, 0);
        vt[5]  = mk(0, 0, 0, 'h00, 1, 0, 0, 'h00, 0, 4, 4, 1, 0, 0, 1, 0, 0);
        vt[6]  = mk(1, 1, 0, 'hE6, 0, 0, 0, 'hA1, 1, 4, 4, 1, 0, 0, 1, 0, 0);
        vt[7]  = mk(0, 1, 0, 'h00, 0, 0, 0, 'hB2, 1, 3, 4, 0, 0, 0, 1, 0, 0);
        vt[8]  = mk(0, 1, 0, 'h00, 0, 0, 0, 'hC3, 1, 2, 4, 0, 0, 0, 0, 0, 0);
        vt[9]  = mk(0, 1, 0, 'h00, 0, 0, 0, 'hD4, 1, 1, 4, 0, 0, 1, 0, 0, 0);
        vt[10] = mk(0, 1, 0, 'h00, 0, 0, 0, 'hE6, 1, 0, 4, 0, 1, 1, 0, 0, 0);
        vt[11] = mk(0, 0, 0, 'h00, 0, 0, 0, 'hE6, 0, 0, 4, 0, 1, 1, 0, 0, 0);
        vt[12] = mk(0, 1, 0, 'h00, 0, 0, 0, 'hE6, 0, 0, 4, 0, 1, 1, 0, 0, 1);
        vt[13] = mk(1, 1, 0, 'h77, 0, 1, 0, 'hE6, 0, 1, 4, 0, 0, 1, 0, 0, 1);
        vt[14] = mk(0, 0, 0, 'h00, 0, 1, 0, 'hE6, 0, 1, 4, 0, 0, 1, 0, 0, 0);
        vt[15] = mk(0, 0, 0, 'h00, 0, 0, 1, 'hE6, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        vt[16] = mk(1, 0, 0, 'h88, 0, 0, 0, 'hE6, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        vt[17] = mk(1, 1, 1, 'h99, 0, 0, 0, 'hE6, 0, 0, 2, 0, 1, 1, 0, 0, 0);
        vt[18] = mk(1, 0, 0, 'hAA, 0, 0, 0, 'hE6, 0, 1, 2, 0, 0, 1, 0, 0, 0);
        vt[19] = mk(0, 1, 0, 'h00, 0, 0, 0, 'hAA, 1, 0, 2, 0, 1, 1, 0, 0, 0);
        vt[20] = mk(0, 1, 1, 'h00, 0, 0, 0, 'hAA, 0, 0, 2, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].wen, vt[i].ren, vt[i].flush, vt[i].wd);
            clr_ovrn_i = vt[i].co; clr_udrn_i = vt[i].cu; clr_hwm_i = vt[i].ch;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_rdata", i), 32'(s4_rdata), 32'(vt[i].rd));
            chk($sformatf("v%0d_valid", i), 32'(s4_valid), 32'(vt[i].vl));
            chk($sformatf("v%0d_lvl", i), 32'(s4_lvl), 32'(vt[i].lvl));
            chk($sformatf("v%0d_hwm", i), 32'(s4_hwm), 32'(vt[i].hwm));
            chk($sformatf("v%0d_full_empty", i), 32'({s4_full, s4_empty}), 32'({vt[i].full, vt[i].empty}));
            chk($sformatf("v%0d_ae_af", i), 32'({s4_ae, s4_af}), 32'({vt[i].ae, vt[i].af}));
            chk($sformatf("v%0d_ovrn_udrn", i), 32'({s4_ovrn, s4_udrn}), 32'({vt[i].ov, vt[i].ud}));
            idle_in();
        end

        // Overrun set beats clear; flush with a write while full is not an overrun.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        clr_ovrn_i = 1'b1;
        step();
        chk("ovrn_set_wins", 32'(s4_ovrn), 1);
        clr_ovrn_i = 1'b1;
        step();
        chk("ovrn_cleared", 32'(s4_ovrn), 0);
        drive(1'b1, 1'b0, 1'b1, 8'h66);
        step();
        chk("flush_full_ovrn", 32'(s4_ovrn), 0);
        chk("flush_full_lvl", 32'(s4_lvl), 0);
        chk("flush_full_hwm", 32'(s4_hwm), 4);

        // Threshold extremes react combinationally.
        ae_thr_i = 3'd0; af_thr_i = 3'd0;
        #1;
        chk("af_thr0", 32'(s4_af), 1);
        chk("ae_thr0_lvl0", 32'(s4_ae), 1);
        ae_thr_i = 3'd4; af_thr_i = 3'd4;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
            step();
        end
        chk("ae_thr_depth", 32'(s4_ae), 1);
        chk("af_thr_depth", 32'(s4_af), 1);
        ae_thr_i = 3'd3; af_thr_i = 3'd5;
        #1;
        chk("ae_thr_change", 32'(s4_ae), 0);
        chk("af_thr_change", 32'(s4_af), 0);
        ae_thr_i = 3'd1; af_thr_i = 3'd3;

        // FWFT instance.
        do_reset();
        chk("fw_rst_valid", 32'(f4_valid), 0);
        chk("fw_rst_rdata", 32'(f4_rdata), 0);
        drive(1'b1, 1'b0, 1'b0, 8'h5A);
        step();
        chk("fw_valid", 32'(f4_valid), 1);
        chk("fw_rdata", 32'(f4_rdata), 32'h5A);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk("fw_pop_empty", 32'(f4_empty), 1);
        chk("fw_pop_rdata", 32'(f4_rdata), 0);
        chk("fw_pop_valid", 32'(f4_valid), 0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk("fw_udrn", 32'(f4_udrn), 1);
        clr_udrn_i = 1'b1;
        step();
        chk("fw_udrn_clr", 32'(f4_udrn), 0);
        drive(1'b1, 1'b0, 1'b0, 8'h11);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'h22);
        step();
        chk("fw_head1", 32'(f4_rdata), 32'h11);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk("fw_head2", 32'(f4_rdata), 32'h22);
        drive(1'b1, 1'b1, 1'b0, 8'h33);
        step();
        chk("fw_rw_head", 32'(f4_rdata), 32'h33);
        chk("fw_rw_lvl", 32'(f4_lvl), 1);

        // DEPTH=5 wrap: 12 writes and 12 reads, pointers wrap twice.
        do_reset();
        begin
            int rd_idx = 0;
            for (int i = 0; i < 15; i++) begin
                logic do_rd;
                do_rd = (i >= 3);
                drive(i < 12, do_rd, 1'b0, 8'(i * 19 + 5));
                step();
                if (do_rd) begin
                    chk($sformatf("wrap_rd%0d", rd_idx), 32'({s5_valid, s5_rdata}),
                        32'({1'b1, 8'(rd_idx * 19 + 5)}));
                    rd_idx++;
                end
            end
            chk("wrap_lvl_end", 32'(s5_lvl), 0);
            chk("wrap_hwm", 32'(s5_hwm), 3);
        end

        // Asynchronous reset between clock edges, then normal operation.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'hC1);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'hC2);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk("pre_arst_rdata", 32'(s4_rdata), 32'hC1);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_lvl", 32'(s4_lvl), 0);
        chk("arst_hwm", 32'(s4_hwm), 0);
        chk("arst_rdata_valid", 32'({s4_valid, s4_rdata}), 0);
        chk("arst_empty", 32'(s4_empty), 1);
        chk("arst_fwft", 32'({f4_valid, f4_rdata}), 0);
        @(negedge clk);
        reset_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h3C);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk("post_arst_rd", 32'({s4_valid, s4_rdata}), 32'({1'b1, 8'h3C}));
        chk("post_arst_lvl", 32'(s4_lvl), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
